// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL lock controller.
// State encodings are fixed because state_o exposes them for debug.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_e;

  localparam int DEF_RST_PULSE_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int DEF_STABLE_CYCLES       = 1024;
  localparam int DEF_CNT_W               = 8;
  localparam int DEF_MAX_RETRIES         = 4;

  // Width able to hold (max-1) of the three cycle limits; never below 1 bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchronizer with synchronous active-high reset to 0.
// Also intended for the pixel-domain reset bridge.
module bit_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_ctrl.sv
// Pixel PLL reset sequencing, lock qualification, timeout retry and loss counting.
// Define PLL_LOCK_CTRL_RETRY_LIMIT_EN to enable the retry limit and FAULT state.
//
// state        | meaning
// PLL_RST      | pll_rst held high for RST_PULSE_CYCLES
// WAIT_LOCK    | PLL released, waiting for synchronized lock, retry on timeout
// STABLE       | lock seen, must stay high STABLE_CYCLES consecutive cycles
// RUN          | qualified lock, ready=1
// FAULT        | retry limit exhausted, held until rst (optional feature only)
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int STABLE_CYCLES       = DEF_STABLE_CYCLES,
  parameter int CNT_W               = DEF_CNT_W,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked_i,
  output logic             pll_rst,
  output logic             ready,
  output logic             fault,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [CNT_W-1:0] retry_cnt
);

  localparam int CW = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);
  localparam logic [CNT_W-1:0] SAT = '1;

  if (RST_PULSE_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 || STABLE_CYCLES < 1 ||
      MAX_RETRIES < 1) begin : g_bad_param
    $error("pll_lock_ctrl: cycle parameters and MAX_RETRIES must be >= 1");
  end

  logic           lk_s;
  pll_state_e     state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic           loss_inc, retry_inc;

  bit_sync2 u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked_i),
    .q   (lk_s)
  );

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt + 1'b1;
    loss_inc  = 1'b0;
    retry_inc = 1'b0;
    case (state)
      ST_PLL_RST: begin
        if (cnt == CW'(RST_PULSE_CYCLES - 1)) begin
          state_nx = ST_WAIT_LOCK;
          cnt_nx   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (lk_s) begin
          state_nx = ST_STABLE;
          cnt_nx   = '0;
        end else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          retry_inc = 1'b1;
          cnt_nx    = '0;
`ifdef PLL_LOCK_CTRL_RETRY_LIMIT_EN
          state_nx  = (retry_cnt == CNT_W'(MAX_RETRIES - 1)) ? ST_FAULT : ST_PLL_RST;
`else
          state_nx  = ST_PLL_RST;
`endif
        end
      end
      ST_STABLE: begin
        if (!lk_s) begin
          state_nx = ST_WAIT_LOCK;
          cnt_nx   = '0;
        end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
          state_nx = ST_RUN;
          cnt_nx   = '0;
        end
      end
      ST_RUN: begin
        cnt_nx = '0;
        if (!lk_s) begin
          state_nx = ST_PLL_RST;
          loss_inc = 1'b1;
        end
      end
`ifdef PLL_LOCK_CTRL_RETRY_LIMIT_EN
      ST_FAULT: begin
        cnt_nx = '0;
      end
`endif
      default: begin
        state_nx = ST_PLL_RST;
        cnt_nx   = '0;
      end
    endcase
  end

  // ready and pll_rst are registered from the next state so they track state exactly.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= ST_PLL_RST;
      cnt       <= '0;
      loss_cnt  <= '0;
      retry_cnt <= '0;
      ready     <= 1'b0;
      pll_rst   <= 1'b1;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      ready   <= (state_nx == ST_RUN);
      pll_rst <= (state_nx == ST_PLL_RST) || (state_nx == ST_FAULT);
      if (loss_inc && loss_cnt != SAT)
        loss_cnt <= loss_cnt + 1'b1;
      if (retry_inc && retry_cnt != SAT)
        retry_cnt <= retry_cnt + 1'b1;
    end
  end

`ifdef PLL_LOCK_CTRL_RETRY_LIMIT_EN
  always_ff @(posedge refclk) begin
    if (rst) fault <= 1'b0;
    else     fault <= (state_nx == ST_FAULT);
  end
`else
  assign fault = 1'b0;
`endif

  assign state_o = state;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with short cycle parameters.
// Inputs are driven and outputs sampled on the falling edge of refclk.
module tb_pll_lock_ctrl;

  localparam int RSTP = 4;
  localparam int TMO  = 20;
  localparam int STB  = 8;
  localparam int CW   = 4;
  localparam int MAXR = 2;

  logic          refclk = 1'b0;
  logic          rst;
  logic          pll_locked_i;
  logic          pll_rst;
  logic          ready;
  logic          fault;
  logic [2:0]    state_o;
  logic [CW-1:0] loss_cnt;
  logic [CW-1:0] retry_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pll_lock_ctrl #(
    .RST_PULSE_CYCLES    (RSTP),
    .LOCK_TIMEOUT_CYCLES (TMO),
    .STABLE_CYCLES       (STB),
    .CNT_W               (CW),
    .MAX_RETRIES         (MAXR)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked_i (pll_locked_i),
    .pll_rst      (pll_rst),
    .ready        (ready),
    .fault        (fault),
    .state_o      (state_o),
    .loss_cnt     (loss_cnt),
    .retry_cnt    (retry_cnt)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic       rst;
    logic       lk;
    logic       pll_rst;
    logic       ready;
    logic [2:0] state;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge refclk);
  endtask

  task automatic chk_all(input string tag, input logic pr, input logic rd, input logic [2:0] st,
                         input logic [CW-1:0] loss, input logic [CW-1:0] retry);
    chk({tag, " pll_rst"},   32'(pll_rst),   32'(pr));
    chk({tag, " ready"},     32'(ready),     32'(rd));
    chk({tag, " state"},     32'(state_o),   32'(st));
    chk({tag, " loss_cnt"},  32'(loss_cnt),  32'(loss));
    chk({tag, " retry_cnt"}, 32'(retry_cnt), 32'(retry));
    chk({tag, " fault"},     32'(fault),     32'(0));
  endtask

  task automatic wait_state(input string name, input logic [2:0] st, input int budget);
    int n = 0;
    while (state_o !== st && n < budget) begin
      tick(1);
      n++;
    end
    chk({name, " reached state"}, 32'(state_o), 32'(st));
  endtask

  task automatic count_ready(input string name, input int exp);
    int n = 0;
    while (ready !== 1'b1 && n < 60) begin
      tick(1);
      n++;
    end
    chk({name, " cycles to ready"}, 32'(n), 32'(exp));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Test 1: reset release with lock high, cycle-by-cycle.
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 3'd0});
    for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 3'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd1});
    for (int i = 0; i < 8; i++) vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd2});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 3'd3});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 3'd3});

    rst = 1'b1;
    pll_locked_i = 1'b1;
    tick(1);
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      pll_locked_i = vecs[i].lk;
      tick(1);
      chk_all($sformatf("vec%0d", i), vecs[i].pll_rst, vecs[i].ready, vecs[i].state, 4'd0, 4'd0);
    end

    // Test 3: one-cycle lock drop in RUN; ready falls on the third edge.
    pll_locked_i = 1'b0;
    tick(1);
    chk("drop edge1 ready", 32'(ready), 32'(1));
    pll_locked_i = 1'b1;
    tick(1);
    chk("drop edge2 ready", 32'(ready), 32'(1));
    tick(1);
    chk_all("drop edge3", 1'b1, 1'b0, 3'd0, 4'd1, 4'd0);
    tick(3);
    chk("drop pulse end pll_rst", 32'(pll_rst), 32'(1));
    tick(1);
    chk("drop rewait pll_rst", 32'(pll_rst), 32'(0));
    chk("drop rewait state", 32'(state_o), 32'(1));
    tick(1);
    chk("drop stable entry", 32'(state_o), 32'(2));

    // Test 4: lk_s low while the stable count is 5.
    tick(3);
    pll_locked_i = 1'b0;
    tick(1);
    chk("glitch cnt4 state", 32'(state_o), 32'(2));
    pll_locked_i = 1'b1;
    tick(1);
    chk("glitch cnt5 state", 32'(state_o), 32'(2));
    tick(1);
    chk("glitch back to wait", 32'(state_o), 32'(1));
    chk("glitch retry unchanged", 32'(retry_cnt), 32'(0));
    count_ready("glitch requal", 1 + STB);
    chk("glitch loss_cnt", 32'(loss_cnt), 32'(1));

    // Test 3b: full drop-to-ready latency after a second loss.
    pll_locked_i = 1'b0;
    tick(1);
    pll_locked_i = 1'b1;
    tick(2);
    chk("loss2 ready low", 32'(ready), 32'(0));
    chk("loss2 loss_cnt", 32'(loss_cnt), 32'(2));
    count_ready("loss2 requal", RSTP + 1 + STB);

    // Test 6: rst mid-RUN, then mid-STABLE with lock low.
    rst = 1'b1;
    tick(1);
    chk_all("rst in run", 1'b1, 1'b0, 3'd0, 4'd0, 4'd0);
    rst = 1'b0;
    wait_state("post rst", 3'd2, 20);
    tick(3);
    rst = 1'b1;
    pll_locked_i = 1'b0;
    tick(1);
    chk_all("rst in stable", 1'b1, 1'b0, 3'd0, 4'd0, 4'd0);

    // Test 2: no lock, timeouts and re-pulses.
    rst = 1'b0;
    wait_state("nolock", 3'd1, 10);
    n = 0;
    while (state_o === 3'd1 && n < 100) begin
      tick(1);
      n++;
    end
    chk("timeout length", 32'(n), 32'(TMO));
    chk_all("timeout1", 1'b1, 1'b0, 3'd0, 4'd0, 4'd1);
    n = 0;
    while (state_o === 3'd0 && n < 100) begin
      tick(1);
      n++;
    end
    chk("repulse length", 32'(n), 32'(RSTP));
    tick(TMO);
`ifdef PLL_LOCK_CTRL_RETRY_LIMIT_EN
    // Test 5: second timeout hits the retry limit.
    chk("limit state", 32'(state_o), 32'(4));
    chk("limit fault", 32'(fault), 32'(1));
    chk("limit pll_rst", 32'(pll_rst), 32'(1));
    chk("limit retry_cnt", 32'(retry_cnt), 32'(2));
    tick(30);
    chk("fault held state", 32'(state_o), 32'(4));
    chk("fault held fault", 32'(fault), 32'(1));
    rst = 1'b1;
    tick(1);
    chk_all("fault cleared", 1'b1, 1'b0, 3'd0, 4'd0, 4'd0);
    rst = 1'b0;
`else
    chk_all("timeout2", 1'b1, 1'b0, 3'd0, 4'd0, 4'd2);
    tick(18 * (TMO + RSTP));
    chk_all("timeout20 saturated", 1'b1, 1'b0, 3'd0, 4'd0, 4'd15);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_ctrl.md
Name: pll_lock_ctrl

Overview:
- Sits on the reference-clock side of the pixel PLL and consumes its outputs.
- Drives the PLL reset input and synchronizes the asynchronous `locked` output.
- Qualifies lock stability, retries on lock timeout and counts lock losses.
- Produces a registered `ready` level for the pixel-domain reset bridge; nothing downstream of the pixel clock is released until `ready`=1.

Parameters:
- RST_PULSE_CYCLES, 16: cycles `pll_rst` is held high per reset attempt (>=1).
- LOCK_TIMEOUT_CYCLES, 50000: WAIT_LOCK cycles before retrying (1 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before `ready`.
- CNT_W, 8: width of the loss and retry counters (saturating).
- MAX_RETRIES, 4: retry limit; used only with the optional feature.

Ports:
- refclk, in, 1: 50 MHz reference clock; the block's only clock.
- rst, in, 1: reset; synchronous to `refclk`, active-high.
- pll_locked_i, in, 1: PLL `locked`; asynchronous to `refclk`.
- pll_rst, out, 1: drives the PLL `rst` input.
- ready, out, 1: PLL locked and qualified; pixel domain may leave reset.
- fault, out, 1: retry limit exhausted; constant 0 without the optional feature.
- state_o, out, 3: current FSM state encoding, for debug.
- loss_cnt, out, CNT_W: RUN-to-lock-loss events, saturating.
- retry_cnt, out, CNT_W: lock timeouts, saturating.

Behaviour:
- Reset values (while `rst`=1): `pll_rst`=1, `ready`=0, `fault`=0, state=PLL_RST, all counters 0, synchronizer flops 0. `rst` dominates every other event.
- Synchronizer: 2-flop chain, `pll_locked_i` -> `lk_s`. Only `lk_s` is used; input-to-`lk_s` latency is 2 cycles.
- PLL_RST:
  - `pll_rst`=1; counter increments each cycle.
  - At count == RST_PULSE_CYCLES-1, go to WAIT_LOCK with the counter cleared.
  - Net effect: `pll_rst` high for exactly RST_PULSE_CYCLES cycles after `rst` falls or after entry.
  - `lk_s` is ignored here.
- WAIT_LOCK:
  - `pll_rst`=0; counter increments.
  - `lk_s`=1 -> STABLE, counter cleared.
  - Otherwise, at count == LOCK_TIMEOUT_CYCLES-1 -> PLL_RST and `retry_cnt`+1.
  - If `lk_s`=1 on the timeout cycle, lock wins.
- STABLE:
  - `lk_s`=0 -> WAIT_LOCK, counter cleared, no retry increment.
  - At count == STABLE_CYCLES-1 with `lk_s`=1 -> RUN.
- RUN:
  - `ready`=1, registered, so it is high from the first cycle state==RUN.
  - `lk_s`=0 -> PLL_RST and `loss_cnt`+1; `ready` falls on the same edge the state leaves RUN.
- FAULT: only reachable with the optional feature.
- State encoding: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4. `state_o` is the state register.
- Counters: `loss_cnt` and `retry_cnt` saturate at 2^CNT_W-1 and clear only on `rst`. The internal cycle counter is sized to the largest of the three cycle parameters.
- Minimum lock-to-ready latency: 2 (synchronizer) + 1 (WAIT_LOCK->STABLE) + STABLE_CYCLES cycles.

Optional Feature:
- Macro: PLL_LOCK_CTRL_RETRY_LIMIT_EN.
- Defined:
  - A timeout in WAIT_LOCK when `retry_cnt` already equals MAX_RETRIES-1 increments `retry_cnt` and enters FAULT instead of PLL_RST.
  - FAULT holds `pll_rst`=1, `ready`=0, `fault`=1 until `rst`.
  - Lock losses in RUN never lead to FAULT.
- Undefined:
  - Retries are unbounded.
  - `fault` is tied 0 and the FAULT state is absent.

Decomposition:
- Package `pll_ctrl_pkg`: state enum type and encodings, the default cycle constants, and a `clog2`-based counter-width function.
- One sub-module, `bit_sync2`: the 2-flop synchronizer, reset to 0, reusable for the pixel-domain reset bridge.
- The FSM and counters stay in `pll_lock_ctrl`.

Test Plan (bench parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, STABLE_CYCLES=8, CNT_W=4, MAX_RETRIES=2):
1. `rst` high for 3 cycles, then low, `pll_locked_i`=1 throughout:
   - `pll_rst` high for exactly 4 cycles after `rst` falls.
   - `ready` rises 1+8 cycles after entering WAIT_LOCK; `loss_cnt`=0, `retry_cnt`=0.
2. `pll_locked_i` held 0:
   - WAIT_LOCK times out after 20 cycles and `pll_rst` re-pulses for 4 cycles; `retry_cnt` increments per timeout.
   - Without the macro, after 20 timeouts `retry_cnt` sticks at 15.
3. In RUN, drop `pll_locked_i` for 1 cycle:
   - `ready` falls 3 cycles later (2 synchronizer + 1 state edge) and `loss_cnt`=1.
   - A 4-cycle `pll_rst` pulse follows, then requalification.
4. In STABLE, a locked glitch to 0 at stable count 5:
   - Returns to WAIT_LOCK with `retry_cnt` unchanged.
   - `ready` needs a full 8 further stable cycles.
5. With PLL_LOCK_CTRL_RETRY_LIMIT_EN and `pll_locked_i`=0:
   - After the 2nd timeout, state_o=4, `fault`=1, `pll_rst`=1, `retry_cnt`=2.
   - Asserting `rst` clears everything.
6. Assert `rst` mid-STABLE and again mid-RUN:
   - Next cycle `pll_rst`=1, `ready`=0, state_o=0 and counters 0, regardless of `pll_locked_i`.
